// File: rtl/frame_write_ctrl.sv
// Frame buffer write controller: forwards single pixel writes (latency 1) and
// runs a full-frame raster clear, one write per cycle, with the pixel port stalled.
module frame_write_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_req,
  input  logic [2:0] clear_color,
  output logic       clear_busy,
  output logic       clear_done,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [9:0] pix_x,
  input  logic [8:0] pix_y,
  input  logic [2:0] pix_color,
  output logic       pix_oob,
  output logic [9:0] fb_write_frame_width,
  output logic [8:0] fb_write_frame_height,
  output logic       fb_write_enable,
  output logic [2:0] fb_write_data
);
  localparam logic [0:0]  IDLE   = 1'b0;
  localparam logic [0:0]  CLEAR  = 1'b1;
  localparam logic [9:0]  X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0]  Y_LAST = 9'(HEIGHT - 1);
  // One extra bit so WIDTH=1024 / HEIGHT=512 bounds are representable
  localparam logic [10:0] X_LIM  = 11'(WIDTH);
  localparam logic [9:0]  Y_LIM  = 10'(HEIGHT);

  logic [0:0] state;
  logic [9:0] x_cnt;
  logic [8:0] y_cnt;
  logic [2:0] clr_color;
  logic [9:0] x_nxt;
  logic [8:0] y_nxt;
  logic       last_pos, pix_acc, pix_in;

  assign pix_ready = (state == IDLE) && !rst && !clear_req;
  assign pix_acc   = pix_valid && pix_ready;
  assign pix_in    = ({1'b0, pix_x} < X_LIM) && ({1'b0, pix_y} < Y_LIM);
  // Counters hold the coordinate most recently written during a clear
  assign last_pos  = (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  always_comb begin
    x_nxt = x_cnt + 10'd1;
    y_nxt = y_cnt;
    if (x_cnt == X_LAST) begin
      x_nxt = '0;
      y_nxt = y_cnt + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      x_cnt                 <= '0;
      y_cnt                 <= '0;
      clr_color             <= '0;
      clear_busy            <= 1'b0;
      clear_done            <= 1'b0;
      pix_oob               <= 1'b0;
      fb_write_enable       <= 1'b0;
      fb_write_frame_width  <= '0;
      fb_write_frame_height <= '0;
      fb_write_data         <= '0;
    end else begin
      fb_write_enable <= 1'b0;
      pix_oob         <= 1'b0;
      clear_done      <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            // First clear write (0,0) issues on the accepting edge
            state                 <= CLEAR;
            clr_color             <= clear_color;
            x_cnt                 <= '0;
            y_cnt                 <= '0;
            clear_busy            <= 1'b1;
            clear_done            <= (X_LAST == '0) && (Y_LAST == '0);
            fb_write_enable       <= 1'b1;
            fb_write_frame_width  <= '0;
            fb_write_frame_height <= '0;
            fb_write_data         <= clear_color;
          end else if (pix_acc) begin
            if (pix_in) begin
              fb_write_enable       <= 1'b1;
              fb_write_frame_width  <= pix_x;
              fb_write_frame_height <= pix_y;
              fb_write_data         <= pix_color;
            end else begin
              pix_oob <= 1'b1;
            end
          end
        end
        default: begin
          // Stay one cycle past the last write so busy covers the done cycle
          if (last_pos) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
          end else begin
            x_cnt                 <= x_nxt;
            y_cnt                 <= y_nxt;
            clear_done            <= (x_nxt == X_LAST) && (y_nxt == Y_LAST);
            fb_write_enable       <= 1'b1;
            fb_write_frame_width  <= x_nxt;
            fb_write_frame_height <= y_nxt;
            fb_write_data         <= clr_color;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_frame_write_ctrl.sv
// Bench for frame_write_ctrl (WIDTH=4, HEIGHT=3): a queue-based model predicts
// every cycle's outputs; each scenario task compares inline.
module tb_frame_write_ctrl;
  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst, clear_req, pix_valid;
  logic [2:0] clear_color, pix_color;
  logic [9:0] pix_x;
  logic [8:0] pix_y;
  logic       clear_busy, clear_done, pix_ready, pix_oob, fbe;
  logic [9:0] fbx;
  logic [8:0] fby;
  logic [2:0] fbd;

  always #5 clk = ~clk;

  frame_write_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .pix_oob(pix_oob), .fb_write_frame_width(fbx), .fb_write_frame_height(fby),
    .fb_write_enable(fbe), .fb_write_data(fbd)
  );

  typedef struct packed {logic [9:0] x; logic [8:0] y; logic [2:0] c;} wr_t;
  wr_t        q[$];          // clear writes still to be issued
  logic       busy_m = 1'b0; // model: clear_busy in the current cycle
  logic [9:0] mx = '0;
  logic [8:0] my = '0;
  logic [2:0] md = '0;
  logic       exp_ready, obs_ready, acc;
  logic [25:0] exp_o;
  wire  [25:0] obs_o = {fbe, pix_oob, clear_done, clear_busy, fbx, fby, fbd};
  int n_cmp = 0, n_fail = 0;

  // Advance one clock: predict outputs of the coming edge, then sample #1 after it
  task automatic step();
    logic en, oob, done, busy_n;
    wr_t  w;
    en = 1'b0; oob = 1'b0; done = 1'b0; busy_n = 1'b0;
    #1;
    exp_ready = !rst && !busy_m && !clear_req;
    obs_ready = pix_ready;
    acc       = exp_ready && pix_valid;
    if (rst) begin
      q.delete(); mx = '0; my = '0; md = '0;
    end else if (q.size() > 0) begin
      w = q.pop_front(); en = 1'b1; done = (q.size() == 0); busy_n = 1'b1;
      {mx, my, md} = w;
    end else if (busy_m) begin
      busy_n = 1'b0;
    end else if (clear_req) begin
      for (int yy = 0; yy < H; yy++)
        for (int xx = 0; xx < W; xx++) q.push_back({10'(xx), 9'(yy), clear_color});
      w = q.pop_front(); en = 1'b1; done = (q.size() == 0); busy_n = 1'b1;
      {mx, my, md} = w;
    end else if (acc) begin
      if (int'(pix_x) < W && int'(pix_y) < H) begin
        en = 1'b1; mx = pix_x; my = pix_y; md = pix_color;
      end else oob = 1'b1;
    end
    busy_m = busy_n;
    exp_o  = {en, oob, done, busy_n, mx, my, md};
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; clear_req = 1'b0; pix_valid = 1'b0;
    clear_color = '0; pix_color = '0; pix_x = '0; pix_y = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp += 2;
      if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL reset_ready: got %b want %b", obs_ready, exp_ready); end
      if (obs_o !== exp_o) begin n_fail++; $display("FAIL reset_outs: got %h want %h", obs_o, exp_o); end
    end
    rst = 1'b0;
  endtask

  task automatic test_clear();
    clear_req = 1'b1; clear_color = 3'd5;
    for (int i = 0; i < W * H + 3; i++) begin
      step();
      clear_req = 1'b0;
      // A second request mid-clear with a different colour must be ignored
      if (i == 6) begin clear_req = 1'b1; clear_color = 3'd2; end
      n_cmp += 2;
      if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL clear_ready c%0d: got %b want %b", i, obs_ready, exp_ready); end
      if (obs_o !== exp_o) begin n_fail++; $display("FAIL clear_outs c%0d: got %h want %h", i, obs_o, exp_o); end
    end
  endtask

  task automatic test_pixel_stream();
    logic [21:0] px[5];
    px[0] = {10'd1, 9'd1, 3'd3}; px[1] = {10'd3, 9'd2, 3'd7}; px[2] = {10'd0, 9'd0, 3'd1};
    px[3] = {10'd4, 9'd0, 3'd2}; px[4] = {10'd0, 9'd3, 3'd2};
    for (int i = 0; i < 7; i++) begin
      pix_valid = (i < 5);
      if (i < 5) {pix_x, pix_y, pix_color} = px[i];
      step();
      n_cmp += 2;
      if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL stream_ready p%0d: got %b want %b", i, obs_ready, exp_ready); end
      if (obs_o !== exp_o) begin n_fail++; $display("FAIL stream_outs p%0d: got %h want %h", i, obs_o, exp_o); end
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_collision();
    bit taken = 0;
    clear_req = 1'b1; clear_color = 3'd4;
    pix_valid = 1'b1; pix_x = 10'd2; pix_y = 9'd2; pix_color = 3'd6;
    for (int i = 0; i < W * H + 5; i++) begin
      step();
      if (acc) taken = 1;
      clear_req = (i == 4);
      clear_color = (i == 4) ? 3'd1 : 3'd4;
      if (taken) pix_valid = 1'b0;
      n_cmp += 2;
      if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL collide_ready c%0d: got %b want %b", i, obs_ready, exp_ready); end
      if (obs_o !== exp_o) begin n_fail++; $display("FAIL collide_outs c%0d: got %h want %h", i, obs_o, exp_o); end
    end
    n_cmp++;
    if (!taken) begin n_fail++; $display("FAIL collide_accept: got 0 want 1"); end
    pix_valid = 1'b0; clear_req = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    clear_req = 1'b1; clear_color = 3'd3;
    for (int i = 0; i < W * H + 9; i++) begin
      step();
      clear_req = 1'b0;
      rst = (i == 4);                    // 5th clear write is now visible
      if (i == 6) begin clear_req = 1'b1; clear_color = 3'd6; end
      n_cmp += 2;
      if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rstclr_ready c%0d: got %b want %b", i, obs_ready, exp_ready); end
      if (obs_o !== exp_o) begin n_fail++; $display("FAIL rstclr_outs c%0d: got %h want %h", i, obs_o, exp_o); end
    end
    rst = 1'b0; clear_req = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      clear_req   = ($urandom_range(0, 29) == 0);
      clear_color = 3'($urandom);
      pix_valid   = ($urandom_range(0, 9) < 6);
      pix_x       = 10'($urandom_range(0, W + 1));
      pix_y       = 9'($urandom_range(0, H + 1));
      pix_color   = 3'($urandom);
      step();
      n_cmp += 2;
      if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", i, obs_ready, exp_ready); end
      if (obs_o !== exp_o) begin n_fail++; $display("FAIL rand_outs c%0d: got %h want %h", i, obs_o, exp_o); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_clear();
    test_pixel_stream();
    test_collision();
    test_reset_mid_clear();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
